// File: rtl/ysyx_220066_div_iter.sv
// ysyx_220066_div_iter
// Multi-cycle radix-2 restoring integer divider for the execute stage.
// Handles RISC-V div/divu/rem/remu, including the divide-by-zero and signed
// overflow results. A word mode (is_w) divides the low WLEN bits and
// sign-extends the WLEN-bit result to XLEN.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   valid_in    operation request, taken when ready && valid_in && !flush
//   ready       divider can accept a request this cycle
//   flush       abort any in-flight or completed operation (wins over all)
//   block       downstream stall, holds a completed result
//   src1, src2  dividend, divisor
//   ALUctr      00 div, 01 divu, 10 rem, 11 remu
//   is_w        word mode
//   valid       result valid
//   result      quotient or remainder
//
// state | meaning
// IDLE  | no operation, ready for a request
// CALC  | shift-subtract iterations in progress, cnt holds steps remaining
// DONE  | result valid, held while block is high
module ysyx_220066_div_iter #(
  parameter int XLEN = 64,
  parameter int WLEN = 32,
  parameter int CNTW = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready,
  input  logic            flush,
  input  logic            block,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      ALUctr,
  input  logic            is_w,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;

  // Latched operation
  logic [1:0]      op;
  logic            w_mode;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] dvd;   // remaining dividend bits, MSB-aligned
  logic [XLEN-1:0] dsr;   // divisor magnitude
  logic [XLEN-1:0] rem;   // partial remainder
  logic [XLEN-1:0] quo;   // quotient bits shifted in from the right
  logic [CNTW-1:0] cnt;

  // Operand preparation for the accept cycle
  logic            signed_op;
  logic [XLEN-1:0] a_n, b_n, a_abs, b_abs, min_n, src1_sx, special_res;
  logic            a_neg, b_neg, div_zero, ovf;

  always_comb begin
    signed_op = ~ALUctr[0];
    a_n       = src1;
    b_n       = src2;
    min_n     = {1'b1, {(XLEN-1){1'b0}}};
    src1_sx   = src1;
    if (is_w) begin
      a_n     = signed_op ? {{(XLEN-WLEN){src1[WLEN-1]}}, src1[WLEN-1:0]}
                          : {{(XLEN-WLEN){1'b0}}, src1[WLEN-1:0]};
      b_n     = signed_op ? {{(XLEN-WLEN){src2[WLEN-1]}}, src2[WLEN-1:0]}
                          : {{(XLEN-WLEN){1'b0}}, src2[WLEN-1:0]};
      min_n   = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
      src1_sx = {{(XLEN-WLEN){src1[WLEN-1]}}, src1[WLEN-1:0]};
    end
    a_neg    = signed_op & a_n[XLEN-1];
    b_neg    = signed_op & b_n[XLEN-1];
    a_abs    = a_neg ? -a_n : a_n;
    b_abs    = b_neg ? -b_n : b_n;
    div_zero = (b_n == '0);
    ovf      = signed_op & (a_n == min_n) & (b_n == '1);
    // Divide-by-zero wins over overflow (they cannot coincide anyway)
    if (div_zero)
      special_res = ALUctr[1] ? src1_sx : '1;
    else
      special_res = ALUctr[1] ? '0 : a_n;
  end

  // One restoring step. rem < dsr always holds, so the shifted value is
  // below 2*dsr and the borrow bit of the subtraction is the compare result.
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt, sel, fixed, final_res;

  always_comb begin
    rem_sh  = {rem, dvd[XLEN-1]};
    diff    = rem_sh - {1'b0, dsr};
    ge      = ~diff[XLEN];
    rem_nxt = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], ge};
    sel     = op[1] ? rem_nxt : quo_nxt;
    fixed   = (op[1] ? neg_r : neg_q) ? -sel : sel;
    final_res = w_mode ? {{(XLEN-WLEN){fixed[WLEN-1]}}, fixed[WLEN-1:0]} : fixed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      DONE:    ready = ~block;
      default: ready = 1'b0;
    endcase
    accept = ready & valid_in & ~flush;
    case (state)
      IDLE: if (accept) state_nxt = (div_zero | ovf) ? DONE : CALC;
      CALC: if (cnt == CNTW'(1)) state_nxt = DONE;
      DONE: begin
        if (accept)      state_nxt = (div_zero | ovf) ? DONE : CALC;
        else if (!block) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op     <= '0;
      w_mode <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op     <= ALUctr;
      w_mode <= is_w;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dvd    <= is_w ? (a_abs << (XLEN - WLEN)) : a_abs;
      dsr    <= b_abs;
      rem    <= '0;
      quo    <= '0;
      cnt    <= is_w ? CNTW'(WLEN) : CNTW'(XLEN);
      if (div_zero | ovf) result <= special_res;
    end else if (state == CALC && !flush) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      dvd <= dvd << 1;
      cnt <= cnt - CNTW'(1);
      if (cnt == CNTW'(1)) result <= final_res;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_div_iter.sv
module tb_ysyx_220066_div_iter;

  logic        clk = 1'b0;
  logic        rst, valid_in, flush, block, is_w;
  logic [1:0]  alu;
  logic [63:0] src1, src2;
  logic        ready, valid;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_220066_div_iter #(.XLEN(64), .WLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready(ready), .flush(flush),
    .block(block), .src1(src1), .src2(src2), .ALUctr(alu), .is_w(is_w),
    .valid(valid), .result(result)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: RISC-V division semantics with native arithmetic
  function automatic logic [63:0] model_res(input logic [1:0] op, input bit w,
                                            input logic [63:0] a, input logic [63:0] b);
    int              sa, sb;
    int unsigned     ua, ub;
    longint          la, lb;
    longint unsigned lua, lub;
    logic [31:0]     r32;
    logic [63:0]     r;
    sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    la = a; lb = b; lua = a; lub = b;
    r32 = '0;
    r = '0;
    if (w) begin
      case (op)
        2'b00: if (sb == 0) r32 = '1;
               else if (sa == 32'sh8000_0000 && sb == -1) r32 = sa;
               else r32 = sa / sb;
        2'b01: if (ub == 0) r32 = '1; else r32 = ua / ub;
        2'b10: if (sb == 0) r32 = sa;
               else if (sa == 32'sh8000_0000 && sb == -1) r32 = '0;
               else r32 = sa % sb;
        default: if (ub == 0) r32 = ua; else r32 = ua % ub;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        2'b00: if (lb == 0) r = '1;
               else if (la == 64'sh8000_0000_0000_0000 && lb == -1) r = la;
               else r = la / lb;
        2'b01: if (lub == 0) r = '1; else r = lua / lub;
        2'b10: if (lb == 0) r = la;
               else if (la == 64'sh8000_0000_0000_0000 && lb == -1) r = '0;
               else r = la % lb;
        default: if (lub == 0) r = lua; else r = lua % lub;
      endcase
    end
    return r;
  endfunction

  // Cycles from the accept cycle (cycle 0) to the first cycle with valid high
  function automatic int model_lat(input logic [1:0] op, input bit w,
                                   input logic [63:0] a, input logic [63:0] b);
    bit special;
    if (w) special = (b[31:0] == 0) ||
                     (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   special = (b == 0) ||
                     (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    return special ? 1 : (w ? 33 : 65);
  endfunction

  task automatic scramble_inputs();
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
    alu  = 2'($urandom_range(0, 3));
    is_w = 1'($urandom_range(0, 1));
  endtask

  // Issue one op from IDLE, wait for valid (bounded), then let it be consumed.
  task automatic run_op(input logic [1:0] op, input bit w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    valid_in = 1'b1; alu = op; is_w = w; src1 = a; src2 = b;
    @(posedge clk); #1;
    valid_in = 1'b0;
    scramble_inputs();
    lat = 1;
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; block = 1'b0;
    alu = 2'b00; is_w = 1'b0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready); end
    tests++; if (result !== 64'h0) begin fails++; $display("FAIL reset_result got %h exp 0", result); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (ready !== 1'b1 || valid !== 1'b0)
      begin fails++; $display("FAIL post_reset got ready=%b valid=%b exp 1/0", ready, valid); end
  endtask

  logic [1:0]  d_op  [8] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
  bit          d_w   [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  logic [63:0] d_a   [8] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'h1234,
                             64'hFFFF_FFFF_FFFF_FFFB, 64'h8000_0000_0000_0000,
                             64'h8000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF};
  logic [63:0] d_b   [8] = '{64'd2, 64'd2, 64'd2, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
  logic [63:0] d_exp [8] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB,
                             64'h8000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
  int          d_lat [8] = '{65, 65, 65, 1, 1, 1, 1, 33};

  task automatic test_directed();
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(d_op[i], d_w[i], d_a[i], d_b[i], res, lat);
      tests++; if (res !== d_exp[i])
        begin fails++; $display("FAIL directed_%0d_result got %h exp %h", i, res, d_exp[i]); end
      tests++; if (lat !== d_lat[i])
        begin fails++; $display("FAIL directed_%0d_latency got %0d exp %0d", i, lat, d_lat[i]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, res, exp_r;
    logic [1:0]  op;
    bit          w;
    int          lat, exp_l;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = w ? {$urandom, 32'h0} : 64'h0;
        1: begin
             b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
             a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
           end
        2: b = {$urandom, 32'h0} | 64'($urandom_range(1, 15));
        3: b = 64'($urandom_range(1, 15));
        4: a = 64'($urandom_range(0, 100));
        default: ;
      endcase
      exp_r = model_res(op, w, a, b);
      exp_l = model_lat(op, w, a, b);
      run_op(op, w, a, b, res, lat);
      tests++; if (res !== exp_r)
        begin fails++; $display("FAIL random_%0d op=%0d w=%0d a=%h b=%h got %h exp %h", i, op, w, a, b, res, exp_r); end
      tests++; if (lat !== exp_l)
        begin fails++; $display("FAIL random_%0d_latency got %0d exp %0d", i, lat, exp_l); end
    end
  endtask

  // Leaves the DUT in DONE with block held high.
  task automatic test_block();
    logic [63:0] a, b, exp_r;
    int lat;
    a = {$urandom, $urandom};
    b = {32'h0, $urandom} | 64'h1;
    exp_r = model_res(2'b00, 1'b0, a, b);
    valid_in = 1'b1; alu = 2'b00; is_w = 1'b0; src1 = a; src2 = b;
    @(posedge clk); #1;
    valid_in = 1'b0; block = 1'b1;
    lat = 1;
    while (!valid && lat < 200) begin @(posedge clk); #1; lat++; end
    tests++; if (lat !== 65) begin fails++; $display("FAIL block_latency got %0d exp 65", lat); end
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; scramble_inputs(); src2[0] = 1'b1;
      @(posedge clk); #1;
      tests++; if (valid !== 1'b1 || ready !== 1'b0 || result !== exp_r)
        begin fails++; $display("FAIL block_hold_%0d got valid=%b ready=%b res=%h exp 1/0/%h", i, valid, ready, result, exp_r); end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, exp_r;
    int lat;
    a = {$urandom, $urandom};
    b = 64'($urandom_range(1, 1000));
    exp_r = model_res(2'b01, 1'b0, a, b);
    block = 1'b0; valid_in = 1'b1; alu = 2'b01; is_w = 1'b0; src1 = a; src2 = b;
    @(posedge clk); #1;
    valid_in = 1'b0; scramble_inputs();
    tests++; if (ready !== 1'b0 || valid !== 1'b0)
      begin fails++; $display("FAIL b2b_accept got ready=%b valid=%b exp 0/0", ready, valid); end
    lat = 1;
    while (!valid && lat < 200) begin @(posedge clk); #1; lat++; end
    tests++; if (lat !== 65) begin fails++; $display("FAIL b2b_latency got %0d exp 65", lat); end
    tests++; if (result !== exp_r) begin fails++; $display("FAIL b2b_result got %h exp %h", result, exp_r); end
    // Second handoff directly into a one-cycle divide-by-zero op
    block = 1'b1;
    @(posedge clk); #1;
    a = {$urandom, $urandom};
    exp_r = model_res(2'b10, 1'b1, a, 64'h0);
    block = 1'b0; valid_in = 1'b1; alu = 2'b10; is_w = 1'b1; src1 = a; src2 = '0;
    @(posedge clk); #1;
    valid_in = 1'b0; scramble_inputs();
    tests++; if (valid !== 1'b1 || result !== exp_r)
      begin fails++; $display("FAIL b2b_special got valid=%b res=%h exp 1/%h", valid, result, exp_r); end
    @(posedge clk); #1;
    tests++; if (valid !== 1'b0 || ready !== 1'b1)
      begin fails++; $display("FAIL b2b_drain got valid=%b ready=%b exp 0/1", valid, ready); end
  endtask

  task automatic test_flush();
    logic [63:0] a, b, res, exp_r;
    int lat, rises;
    valid_in = 1'b1; alu = 2'b00; is_w = 1'b0; src1 = 64'd1000; src2 = 64'd7;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if (valid !== 1'b0 || ready !== 1'b1)
      begin fails++; $display("FAIL flush_calc got valid=%b ready=%b exp 0/1", valid, ready); end
    rises = 0;
    repeat (80) begin @(posedge clk); #1; if (valid) rises++; end
    tests++; if (rises !== 0) begin fails++; $display("FAIL flush_no_result got %0d valid cycles exp 0", rises); end
    // Request in the same cycle as flush from IDLE must be dropped
    flush = 1'b1; valid_in = 1'b1; alu = 2'b01; is_w = 1'b0; src1 = 64'h55; src2 = '0;
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    tests++; if (valid !== 1'b0 || ready !== 1'b1)
      begin fails++; $display("FAIL flush_idle_accept got valid=%b ready=%b exp 0/1", valid, ready); end
    // Flush beats block in DONE
    valid_in = 1'b1; alu = 2'b11; is_w = 1'b0; src1 = 64'h99; src2 = '0;
    @(posedge clk); #1;
    valid_in = 1'b0; block = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; block = 1'b0;
    tests++; if (valid !== 1'b0 || ready !== 1'b1)
      begin fails++; $display("FAIL flush_done got valid=%b ready=%b exp 0/1", valid, ready); end
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp_r = model_res(2'b10, 1'b0, a, b);
    run_op(2'b10, 1'b0, a, b, res, lat);
    tests++; if (res !== exp_r) begin fails++; $display("FAIL flush_after_op got %h exp %h", res, exp_r); end
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] a, b, res, exp_r;
    int lat;
    valid_in = 1'b1; alu = 2'b00; is_w = 1'b0; src1 = 64'h1234_5678_9ABC_DEF0; src2 = 64'd3;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (valid !== 1'b0 || ready !== 1'b1 || result !== 64'h0)
      begin fails++; $display("FAIL reset_mid_calc got valid=%b ready=%b res=%h exp 0/1/0", valid, ready, result); end
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    a = {$urandom, $urandom};
    b = {32'h0, $urandom} | 64'h1;
    exp_r = model_res(2'b00, 1'b1, a, b);
    run_op(2'b00, 1'b1, a, b, res, lat);
    tests++; if (res !== exp_r) begin fails++; $display("FAIL reset_after_op got %h exp %h", res, exp_r); end
    tests++; if (lat !== model_lat(2'b00, 1'b1, a, b))
      begin fails++; $display("FAIL reset_after_latency got %0d exp %0d", lat, model_lat(2'b00, 1'b1, a, b)); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_block();
    test_back_to_back();
    test_flush();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_div_iter.md
Name: ysyx_220066_div_iter

Overview:
Parametrised multi-cycle radix-2 integer divider for the execute stage. It replaces the single-cycle behavioural divider with a shift-subtract datapath, which removes the long combinational divide path. It keeps the same valid_in/ready/valid/block handshake and ALUctr encoding. It adds RISC-V divide-by-zero and overflow semantics, a word-mode width parameter, and a flush input.

Parameters:
XLEN, 64, full operand/result width; even, >= 16
WLEN, 32, word-mode (is_w) operand width; WLEN < XLEN
CNTW, $clog2(XLEN+1), iteration counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
valid_in  in  1  operation request
ready  out  1  divider can accept a request this cycle
flush  in  1  abort in-flight operation (pipeline redirect)
block  in  1  downstream stall; holds the completed result
src1  in  XLEN  dividend
src2  in  XLEN  divisor
ALUctr  in  2  00 div, 01 divu, 10 rem, 11 remu
is_w  in  1  word mode: use src[WLEN-1:0], sign-extend result
valid  out  1  result valid
result  out  XLEN  quotient or remainder

Behaviour:
- Reset (async): state=IDLE, valid=0, result=0, counter=0, all datapath regs=0. ready=1 after reset.
- States:
  - IDLE: ready=1.
  - CALC: ready=0.
  - DONE: valid=1; ready=~block.
- Accept condition: ready && valid_in && !flush.
  - On accept, latch ALUctr, is_w, operand signs and absolute values (N=WLEN if is_w else XLEN).
  - Signed ops use the magnitude of the two's-complement operands.
- Special cases on accept, decided from the latched operands:
  - Divisor zero: quotient=all ones; remainder=dividend (N-bit).
  - Signed overflow (dividend=-2^(N-1), divisor=-1): quotient=dividend; remainder=0.
  - Both go directly to DONE; valid rises the next cycle (latency 1).
- Normal case: CALC runs exactly N iterations, one restoring shift-subtract step per cycle.
  - Each step: shift the partial remainder left by 1 and bring in the next dividend bit. If the partial remainder >= divisor, subtract and set the quotient bit.
  - After N cycles, go to DONE. valid is high N+1 cycles after the accept edge.
- Sign fix-up, applied in the final step:
  - Quotient is negated if the dividend and divisor signs differ (signed ops only).
  - Remainder is negated if the dividend is negative (signed ops only).
- Word mode: the N-bit result is sign-extended to XLEN for all four ops, including divu/remu.
- DONE:
  - block=1: hold valid and result stable; ready=0.
  - block=0: the result is consumed this cycle.
    - If valid_in is also high, accept the new op in the same cycle (back-to-back, no bubble).
    - Otherwise go to IDLE and valid drops.
- flush:
  - Any state goes to IDLE next cycle; valid=0; any accept in that cycle is ignored.
  - result keeps its old value (don't-care).
  - flush takes priority over block and valid_in.
- Inputs src1/src2/ALUctr/is_w are don't-care outside the accept cycle; all are latched.
- valid_in while in CALC is ignored (ready=0). Upstream must hold its request.
- rst asserted mid-CALC: immediate return to IDLE, outputs cleared, no partial result.

Test Plan:
- Reset mid-CALC: assert rst while the counter is mid-way → valid=0, ready=1 immediately; next accepted op completes correctly.
- XLEN=64 div: src1=-7, src2=2 → quotient -3 (0xFFFF_FFFF_FFFF_FFFD), valid at cycle 65 after accept. Same operands with rem → -1. With remu, src1=7, src2=2 → 1.
- Divide by zero, 1-cycle latency:
  - divu src1=0x1234, src2=0 → 0xFFFF_FFFF_FFFF_FFFF.
  - rem src1=-5, src2=0 → -5.
  - Both valid the cycle after accept.
- Overflow and word mode:
  - div src1=0x8000_0000_0000_0000, src2=-1 → 0x8000_0000_0000_0000, rem → 0.
  - is_w divu src1=0xFFFF_FFFF, src2=1 → 0xFFFF_FFFF_FFFF_FFFF (sign-extended); done at cycle 33.
- Handshake:
  - Hold block=1 for 5 cycles in DONE → valid and result stable, ready=0.
  - Release block with valid_in=1 → new op accepted on the same edge, no idle cycle.
- Flush: assert flush mid-CALC → valid stays 0, state IDLE next cycle; a following op returns a correct result.
